// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit for the EX stage.
// Runs MUL/MULH/MULHU/DIV/DIVU/REM/REMU with a fixed latency of WIDTH+2 cycles
// from start to done, so that the hazard unit can stall deterministically.
// A single 2*WIDTH register holds the running product for multiplies and the
// {remainder, quotient} pair for divides.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       MDControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] MDResult,
    output logic             Zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULH  = 3'b001;
    localparam logic [2:0] OP_MULHU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_REM   = 3'b101;
    localparam logic [2:0] OP_REMU  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Two's complement negation of a WIDTH-bit word when neg is set.
    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Two's complement negation of a 2*WIDTH-bit word when neg is set.
    function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Ops that treat their operands as two's complement.
    function automatic logic f_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Ops that use the shift-subtract datapath.
    function automatic logic f_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_op;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic [2*WIDTH-1:0]   r_prod;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_result;

    logic                 w_launch;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_fix_result;

    // Operand conditioning at launch: magnitudes for signed ops, raw otherwise.
    always_comb begin
        w_launch = (r_state == S_IDLE) && start && !flush;
        w_sign_a = f_is_signed(MDControl) && SrcA[WIDTH-1];
        w_sign_b = f_is_signed(MDControl) && SrcB[WIDTH-1];
        w_abs_a  = f_neg_w(SrcA, w_sign_a);
        w_abs_b  = f_neg_w(SrcB, w_sign_b);
    end

    // One iteration of radix-2 shift-add and of restoring shift-subtract.
    always_comb begin
        w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opa} : '0);
        w_mul_step  = {w_mul_sum, r_prod[WIDTH-1:1]};
        w_div_shift = r_prod[2*WIDTH-1:WIDTH-1];
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        if (!w_div_diff[WIDTH]) begin
            w_div_step = {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
        end else begin
            w_div_step = {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and result-word selection used in FIX.
    always_comb begin
        w_prod_fix = f_neg_2w(r_prod, r_sign_a ^ r_sign_b);
        // A zero divisor must give all ones regardless of the dividend sign.
        w_quot_fix = (r_opb == '0) ? '1 : f_neg_w(r_prod[WIDTH-1:0], r_sign_a ^ r_sign_b);
        // Remainder follows the dividend; with a zero divisor this restores SrcA.
        w_rem_fix  = f_neg_w(r_prod[2*WIDTH-1:WIDTH], r_sign_a);
        case (r_op)
            OP_MUL:            w_fix_result = w_prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHU: w_fix_result = w_prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   w_fix_result = w_quot_fix;
            OP_REM, OP_REMU:   w_fix_result = w_rem_fix;
            default:           w_fix_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake outputs; flush aborts CALC/FIX only.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) w_next = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (flush)                  w_next = S_IDLE;
                else if (r_cnt == LAST_CNT) w_next = S_FIX;
            end
            S_FIX: begin
                busy = 1'b1;
                if (flush) w_next = S_IDLE;
                else       w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture at launch and one iteration per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (w_launch) begin
            r_op     <= MDControl;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_opa    <= w_abs_a;
            r_opb    <= w_abs_b;
            r_cnt    <= '0;
            r_prod   <= f_is_div(MDControl) ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
        end else if (r_state == S_CALC && !flush) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_prod   <= f_is_div(r_op) ? w_div_step : w_mul_step;
        end
    end

    // Result register: loaded only by a FIX cycle that is not aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (r_state == S_FIX && !flush) begin
            r_result <= w_fix_result;
        end
    end

    assign MDResult = r_result;
    assign Zero     = (r_result == '0);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (WIDTH = 32).
// Cycle numbering: the cycle in which start is high is cycle 0; outputs are
// sampled 1 time unit after each rising edge.
module tb_md_unit;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULH  = 3'b001;
    localparam logic [2:0] OP_MULHU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_REM   = 3'b101;
    localparam logic [2:0] OP_REMU  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  MDControl = 3'b000;
    logic [31:0] SrcA = 32'h0;
    logic [31:0] SrcB = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] MDResult;
    logic        Zero;

    int n_pass  = 0;
    int n_total = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .MDControl (MDControl),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .busy      (busy),
        .done      (done),
        .MDResult  (MDResult),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one op from IDLE, wait (bounded) for done, return the result,
    // the cycle number of done (-1 on timeout) and the number of busy cycles.
    // Leaves the bench in the cycle after the done pulse.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int nbusy);
        MDControl = op;
        SrcA      = a;
        SrcB      = b;
        start     = 1'b1;
        step();
        start     = 1'b0;
        MDControl = 3'b111;
        SrcA      = 32'hDEADBEEF;
        SrcB      = 32'h12345678;
        lat       = 1;
        nbusy     = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nbusy++;
            step();
            lat++;
        end
        res = MDResult;
        if (done !== 1'b1) lat = -1;
        step();
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_total++; if (MDResult !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", MDResult); else n_pass++;
        n_total++; if (Zero !== 1'b1) $display("FAIL reset_zero: got %b expected 1", Zero); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mul();
        logic [31:0] res;
        int lat, nb;
        run_op(OP_MUL, 32'h00000007, 32'hFFFFFFFD, res, lat, nb);
        n_total++; if (res !== 32'hFFFFFFEB) $display("FAIL mul_result: got %h expected ffffffeb", res); else n_pass++;
        n_total++; if (lat != 34) $display("FAIL mul_latency: got %0d expected 34", lat); else n_pass++;
        n_total++; if (nb != 33) $display("FAIL mul_busy_cycles: got %0d expected 33", nb); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL mul_done_width: got %b expected 0", done); else n_pass++;
        run_op(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, nb);
        n_total++; if (res !== 32'h00000000) $display("FAIL mulh_m1: got %h expected 00000000", res); else n_pass++;
        n_total++; if (Zero !== 1'b1) $display("FAIL mulh_zero: got %b expected 1", Zero); else n_pass++;
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, nb);
        n_total++; if (res !== 32'hFFFFFFFE) $display("FAIL mulhu_max: got %h expected fffffffe", res); else n_pass++;
        n_total++; if (Zero !== 1'b0) $display("FAIL mulhu_zero: got %b expected 0", Zero); else n_pass++;
        run_op(OP_MULH, 32'h80000000, 32'h00000002, res, lat, nb);
        n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL mulh_neg: got %h expected ffffffff", res); else n_pass++;
        run_op(OP_MULHU, 32'h80000000, 32'h00000002, res, lat, nb);
        n_total++; if (res !== 32'h00000001) $display("FAIL mulhu_pos: got %h expected 00000001", res); else n_pass++;
        run_op(OP_MUL, 32'h12345678, 32'h00000010, res, lat, nb);
        n_total++; if (res !== 32'h23456780) $display("FAIL mul_low: got %h expected 23456780", res); else n_pass++;
    endtask

    task automatic test_div();
        logic [31:0] res;
        int lat, nb;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, res, lat, nb);
        n_total++; if (res !== 32'hFFFFFFFD) $display("FAIL div_neg: got %h expected fffffffd", res); else n_pass++;
        n_total++; if (lat != 34) $display("FAIL div_latency: got %0d expected 34", lat); else n_pass++;
        run_op(OP_REM, 32'hFFFFFFF9, 32'h00000002, res, lat, nb);
        n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL rem_neg: got %h expected ffffffff", res); else n_pass++;
        run_op(OP_DIVU, 32'd100, 32'd7, res, lat, nb);
        n_total++; if (res !== 32'd14) $display("FAIL divu: got %h expected 0000000e", res); else n_pass++;
        run_op(OP_REMU, 32'd100, 32'd7, res, lat, nb);
        n_total++; if (res !== 32'd2) $display("FAIL remu: got %h expected 00000002", res); else n_pass++;
        run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, res, lat, nb);
        n_total++; if (res !== 32'h7FFFFFFC) $display("FAIL divu_big: got %h expected 7ffffffc", res); else n_pass++;
    endtask

    task automatic test_div_special();
        logic [31:0] res;
        int lat, nb;
        run_op(OP_DIV, 32'd5, 32'd0, res, lat, nb);
        n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL div_by_zero: got %h expected ffffffff", res); else n_pass++;
        n_total++; if (lat != 34) $display("FAIL div0_latency: got %0d expected 34", lat); else n_pass++;
        run_op(OP_REM, 32'd5, 32'd0, res, lat, nb);
        n_total++; if (res !== 32'd5) $display("FAIL rem_by_zero: got %h expected 00000005", res); else n_pass++;
        run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, res, lat, nb);
        n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL div_neg_by_zero: got %h expected ffffffff", res); else n_pass++;
        run_op(OP_REMU, 32'hFFFFFFF9, 32'd0, res, lat, nb);
        n_total++; if (res !== 32'hFFFFFFF9) $display("FAIL remu_by_zero: got %h expected fffffff9", res); else n_pass++;
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, res, lat, nb);
        n_total++; if (res !== 32'h80000000) $display("FAIL div_overflow: got %h expected 80000000", res); else n_pass++;
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, res, lat, nb);
        n_total++; if (res !== 32'h0) $display("FAIL rem_overflow: got %h expected 00000000", res); else n_pass++;
        n_total++; if (Zero !== 1'b1) $display("FAIL rem_overflow_zero: got %b expected 1", Zero); else n_pass++;
        run_op(OP_MUL, 32'd3, 32'd3, res, lat, nb);
        run_op(OP_RSVD, 32'd3, 32'd3, res, lat, nb);
        n_total++; if (res !== 32'h0) $display("FAIL reserved_result: got %h expected 00000000", res); else n_pass++;
        n_total++; if (lat != 34) $display("FAIL reserved_latency: got %0d expected 34", lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, nb;
        run_op(OP_DIVU, 32'd1000, 32'd10, res, lat, nb);
        n_total++; if (res !== 32'd100) $display("FAIL b2b_first: got %h expected 00000064", res); else n_pass++;
        run_op(OP_MUL, 32'd6, 32'd7, res, lat, nb);
        n_total++; if (res !== 32'd42) $display("FAIL b2b_second: got %h expected 0000002a", res); else n_pass++;
        n_total++; if (lat != 34) $display("FAIL b2b_latency: got %0d expected 34", lat); else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, nb, ndone;
        run_op(OP_REMU, 32'd100, 32'd7, res, lat, nb);
        // cycle 0: launch DIVU 1000/3
        MDControl = OP_DIVU;
        SrcA      = 32'd1000;
        SrcB      = 32'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c < 10; c++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        // cycle 10: abort
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (ndone != 0 || done !== 1'b0) $display("FAIL flush_no_done: got %0d/%b expected 0/0", ndone, done); else n_pass++;
        n_total++; if (MDResult !== 32'd2) $display("FAIL flush_keep_result: got %h expected 00000002", MDResult); else n_pass++;
        step();
        // cycle 12: fresh launch, done expected 34 cycles later (cycle 46)
        run_op(OP_DIVU, 32'd1000, 32'd3, res, lat, nb);
        n_total++; if (res !== 32'd333) $display("FAIL flush_restart_result: got %h expected 0000014d", res); else n_pass++;
        n_total++; if (lat != 34) $display("FAIL flush_restart_latency: got %0d expected 34", lat); else n_pass++;
        // flush together with start in IDLE: nothing launches
        MDControl = OP_MUL;
        SrcA      = 32'd2;
        SrcB      = 32'd2;
        start     = 1'b1;
        flush     = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL flush_start_busy: got %b expected 0", busy); else n_pass++;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        n_total++; if (ndone != 0 || MDResult !== 32'd333) $display("FAIL flush_start_ignored: got %0d/%h expected 0/0000014d", ndone, MDResult); else n_pass++;
    endtask

    task automatic test_start_ignored_and_reset();
        int lat, ndone;
        // cycle 0: MUL 7 x -3, with a competing start pulse at cycle 5
        MDControl = OP_MUL;
        SrcA      = 32'h00000007;
        SrcB      = 32'hFFFFFFFD;
        start     = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1; MDControl = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) lat = -1;
        n_total++; if (lat != 34) $display("FAIL restart_ignored_latency: got %0d expected 34", lat); else n_pass++;
        n_total++; if (MDResult !== 32'hFFFFFFEB) $display("FAIL restart_ignored_result: got %h expected ffffffeb", MDResult); else n_pass++;
        // start held during the done cycle must not launch either
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        n_total++; if (ndone != 0) $display("FAIL single_done: got %0d extra pulses expected 0", ndone); else n_pass++;
        // asynchronous reset in the middle of an op
        MDControl = OP_DIVU;
        SrcA      = 32'd100;
        SrcB      = 32'd7;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL midop_reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (MDResult !== 32'h0 || Zero !== 1'b1) $display("FAIL midop_reset_result: got %h/%b expected 00000000/1", MDResult, Zero); else n_pass++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        n_total++; if (ndone != 0) $display("FAIL midop_reset_quiet: got %0d active cycles expected 0", ndone); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_back_to_back();
        test_flush();
        test_start_ignored_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
